pulse_stretcher: RTL

PULSE_STRETCHER -- requirements
Module: pulse_stretcher

---
 rtl/pulse_stretcher_if.sv | 14 +
 rtl/pulse_stretcher.sv | 107 ++++++++++
 2 files changed

// File: rtl/pulse_stretcher_if.sv
// Request/status bundle of the pulse stretcher: one request line in, stretched
// pulse plus queue status out.
interface pulse_stretcher_if #(
  parameter int unsigned PEND_W = 2
);
  logic              In;
  logic              Out;
  logic              busy;
  logic [PEND_W-1:0] pend;
  logic              ovf;

  modport master (output In, input  Out, busy, pend, ovf);
  modport slave  (input  In, output Out, busy, pend, ovf);
endinterface

// File: rtl/pulse_stretcher.sv
// Stretches each accepted request into a HOLD-cycle high burst followed by GAP
// forced-low cycles; requests arriving mid-burst are queued up to 2^PEND_W-1.
module pulse_stretcher #(
  parameter int unsigned HOLD   = 4,
  parameter int unsigned GAP    = 2,
  parameter int unsigned PEND_W = 2
) (
  input  logic               clk,
  input  logic               reset,
  pulse_stretcher_if.slave   ps
);

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_GAP} state_t;

  localparam logic [7:0]        HOLD_LD  = 8'(HOLD - 1);
  localparam logic [7:0]        GAP_LD   = (GAP > 0) ? 8'(GAP - 1) : 8'd0;
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              ovf_q, ovf_d;
  logic              out_q, busy_q;
  logic              decide;
  logic              queue_req;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    ovf_d     = ovf_q;
    decide    = 1'b0;
    queue_req = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (ps.In) begin
          state_d = S_HOLD;
          cnt_d   = HOLD_LD;
        end
      end
      S_HOLD: begin
        queue_req = ps.In;
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else if (GAP > 0) begin
          state_d = S_GAP;
          cnt_d   = GAP_LD;
        end else begin
          decide = 1'b1;
        end
      end
      S_GAP: begin
        queue_req = ps.In;
        if (cnt_q != 8'd0) cnt_d = cnt_q - 8'd1;
        else               decide = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // End of burst: a queued request wins; a live request is consumed here
    // instead of being queued, so a simultaneous pop+push leaves pend as-is.
    if (decide) begin
      queue_req = 1'b0;
      if (pend_q != '0) begin
        state_d = S_HOLD;
        cnt_d   = HOLD_LD;
        if (!ps.In) pend_d = pend_q - PEND_W'(1);
      end else if (ps.In) begin
        state_d = S_HOLD;
        cnt_d   = HOLD_LD;
      end else begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    end

    if (queue_req) begin
      if (pend_q != PEND_MAX) pend_d = pend_q + PEND_W'(1);
      else                    ovf_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
      out_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      out_q   <= (state_d == S_HOLD);
      busy_q  <= (state_d != S_IDLE);
    end
  end

  assign ps.Out  = out_q;
  assign ps.busy = busy_q;
  assign ps.pend = pend_q;
  assign ps.ovf  = ovf_q;

endmodule
